// File: rtl/c1541_head_stepper_if.sv
// Signal bundle between the drive logic / track loader side and the head stepper.
// The master drives the stepper phase, motor and write controls; the slave reports head state.
interface c1541_head_stepper_if;
  logic [1:0] stp;
  logic       mtr;
  logic       buff_we;
  logic       disk_change;
  logic       busy;
  logic [6:0] half_track;
  logic       tr00_sense_n;
  logic       save_track;
  logic       settled;

  modport master (
    output stp, mtr, buff_we, disk_change, busy,
    input  half_track, tr00_sense_n, save_track, settled
  );

  modport slave (
    input  stp, mtr, buff_we, disk_change, busy,
    output half_track, tr00_sense_n, save_track, settled
  );
endinterface

// File: rtl/c1541_head_stepper.sv
// Head positioning: decodes stepper phases into a saturating half-track position,
// requests a track save when a dirty track is left, and flags head settling.
module c1541_head_stepper #(
  parameter int TRACK_MAX  = 83,
  parameter int TRACK_INIT = 36,
  parameter int SETTLE_CYC = 96000
) (
  input logic                  clk32,
  input logic                  reset_n,
  c1541_head_stepper_if.slave  bus
);

  localparam int         CW      = $clog2(SETTLE_CYC + 1);
  localparam logic [6:0] HT_MAX  = 7'(TRACK_MAX);
  localparam logic [6:0] HT_INIT = 7'(TRACK_INIT);

  typedef enum logic {S_IDLE, S_PEND} save_state_t;

  save_state_t   r_state;
  save_state_t   w_state_next;
  logic [6:0]    r_half_track;
  logic [1:0]    r_stp;
  logic          r_mtr;
  logic          r_modified;
  logic          r_save_track;
  logic          w_save_next;
  logic [CW-1:0] r_settle_cnt;
  logic          r_settled;

  logic w_step_up;
  logic w_step_dn;
  logic w_step;
  logic w_mod_eff;
  logic w_trigger;

  // Adjacent phase forward/backward is a step; a double jump (xor 2'b10) matches neither.
  assign w_step_up = bus.mtr && (bus.stp == 2'(r_stp + 2'd1));
  assign w_step_dn = bus.mtr && (bus.stp == 2'(r_stp - 2'd1));
  assign w_step    = w_step_up || w_step_dn;
  assign w_mod_eff = r_modified || bus.buff_we;
  assign w_trigger = (w_step || (r_mtr && !bus.mtr)) && w_mod_eff && !bus.disk_change;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values;
  // async reset puts all state, including the settle counter, at a known value.
  always_ff @(posedge clk32 or negedge reset_n) begin
    if (!reset_n) begin
      r_half_track <= HT_INIT;
      r_stp        <= 2'd0;
      r_mtr        <= 1'b0;
      r_modified   <= 1'b0;
    end else begin
      r_stp <= bus.stp;
      r_mtr <= bus.mtr;
      if (w_step_up && (r_half_track != HT_MAX)) begin
        r_half_track <= r_half_track + 7'd1;
      end else if (w_step_dn && (r_half_track != 7'd0)) begin
        r_half_track <= r_half_track - 7'd1;
      end
      // A write in the same cycle as a step belongs to the track being left.
      if (bus.disk_change || w_trigger) begin
        r_modified <= 1'b0;
      end else if (bus.buff_we) begin
        r_modified <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk32 or negedge reset_n) begin
    if (!reset_n) begin
      r_settle_cnt <= '0;
      r_settled    <= 1'b1;
    end else if (w_step) begin
      r_settle_cnt <= CW'(SETTLE_CYC - 1);
      r_settled    <= 1'b0;
    end else if (r_settle_cnt != '0) begin
      r_settle_cnt <= r_settle_cnt - CW'(1);
    end else begin
      r_settled    <= 1'b1;
    end
  end

  always_ff @(posedge clk32 or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_save_track <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_save_track <= w_save_next;
    end
  end

  // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_save_next  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_trigger) begin
          // A pulse just issued forces the new request to wait, so pulses never abut.
          if (!bus.busy && !r_save_track) begin
            w_save_next = 1'b1;
          end else begin
            w_state_next = S_PEND;
          end
        end
      end
      S_PEND: begin
        if (bus.disk_change) begin
          w_state_next = S_IDLE;
        end else if (!bus.busy && !r_save_track) begin
          w_save_next  = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign bus.half_track   = r_half_track;
  assign bus.tr00_sense_n = |r_half_track;
  assign bus.save_track   = r_save_track;
  assign bus.settled      = r_settled;

endmodule

// File: tb/tb_c1541_head_stepper.sv
// Randomized and directed bench for c1541_head_stepper against a cycle-level
// behavioural model built from phase arithmetic and request/settle time bookkeeping.
module tb_c1541_head_stepper;

  localparam int N     = 64;
  localparam int T_MAX = 83;
  localparam int T_INI = 36;

  logic clk32   = 1'b0;
  logic reset_n = 1'b0;

  c1541_head_stepper_if bus();

  c1541_head_stepper #(
    .TRACK_MAX (T_MAX),
    .TRACK_INIT(T_INI),
    .SETTLE_CYC(N)
  ) dut (
    .clk32  (clk32),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk32 = ~clk32;

  int n_vec  = 0;
  int n_err  = 0;
  int pulses = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: position, dirty flag, outstanding save request, cycles since last step.
  int m_ht, m_stp_prev, m_since;
  bit m_mtr_prev, m_mod, m_pending, m_pulse;
  int d;
  bit step, trig, want, fire;

  always @(posedge clk32 or negedge reset_n) begin
    if (!reset_n) begin
      m_ht = T_INI; m_stp_prev = 0; m_mtr_prev = 0; m_mod = 0;
      m_pending = 0; m_pulse = 0; m_since = N;
    end else begin
      d    = (int'(bus.stp) - m_stp_prev + 4) % 4;
      step = bus.mtr && (d == 1 || d == 3);
      trig = (step || (m_mtr_prev && !bus.mtr)) && (m_mod || bus.buff_we) && !bus.disk_change;
      if (bus.disk_change) m_pending = 0;
      want      = m_pending || trig;
      fire      = want && !bus.busy && !m_pulse;
      m_pending = want && !fire;
      m_pulse   = fire;
      if (bus.disk_change || trig) m_mod = 0;
      else if (bus.buff_we)        m_mod = 1;
      if (step) begin
        if (d == 1) m_ht = (m_ht < T_MAX) ? m_ht + 1 : T_MAX;
        else        m_ht = (m_ht > 0) ? m_ht - 1 : 0;
        m_since = 0;
      end else if (m_since < N) begin
        m_since++;
      end
      m_stp_prev = int'(bus.stp);
      m_mtr_prev = bus.mtr;
    end
  end

  always @(negedge clk32) begin
    if (bus.save_track) pulses++;
    if (cmp_en) begin
      check("half_track",   int'(bus.half_track),   m_ht);
      check("tr00_sense_n", int'(bus.tr00_sense_n), (m_ht != 0) ? 1 : 0);
      check("save_track",   int'(bus.save_track),   int'(m_pulse));
      check("settled",      int'(bus.settled),      (m_since >= N) ? 1 : 0);
    end
  end

  task automatic tick();
    @(posedge clk32);
    #1;
  endtask

  task automatic step_by(input int n);
    bus.stp = 2'(int'(bus.stp) + n);
    tick();
  endtask

  int p0;
  int cnt;

  initial begin
    bus.stp = 2'd0; bus.mtr = 1'b0; bus.buff_we = 1'b0;
    bus.disk_change = 1'b0; bus.busy = 1'b0;
    #12;
    check("rst_half_track", int'(bus.half_track), 36);
    check("rst_save",       int'(bus.save_track), 0);
    check("rst_settled",    int'(bus.settled), 1);
    check("rst_tr00",       int'(bus.tr00_sense_n), 1);
    tick();
    reset_n = 1'b1;
    cmp_en  = 1'b1;

    // Phase walk upward
    bus.mtr = 1'b1;
    tick();
    step_by(1); check("walk_37", int'(bus.half_track), 37);
    step_by(1); check("walk_38", int'(bus.half_track), 38);
    step_by(1); check("walk_39", int'(bus.half_track), 39);
    step_by(1); check("walk_40", int'(bus.half_track), 40);
    check("walk_no_save", pulses, 0);

    // Upper saturation and settle duration
    repeat (43) step_by(1);
    check("at_max", int'(bus.half_track), 83);
    step_by(1);
    check("sat_max", int'(bus.half_track), 83);
    cnt = 0;
    while (!bus.settled && cnt < N + 10) begin
      cnt++;
      tick();
    end
    check("settle_low_cycles", cnt, N);

    // Lower saturation
    repeat (83) step_by(-1);
    check("at_zero", int'(bus.half_track), 0);
    step_by(-1);
    check("sat_zero", int'(bus.half_track), 0);
    check("tr00_low", int'(bus.tr00_sense_n), 0);

    // Dirty track saved on step, one cycle later
    step_by(1); step_by(1);
    p0 = pulses;
    bus.buff_we = 1'b1; tick(); bus.buff_we = 1'b0;
    step_by(-1);
    check("save_on_step", int'(bus.save_track), 1);
    check("ht_after_save_step", int'(bus.half_track), 1);
    tick();
    check("save_one_cycle", int'(bus.save_track), 0);
    step_by(-1);
    repeat (5) tick();
    check("single_pulse_clean_step", pulses, p0 + 1);

    // Motor stop while loader busy: deferred save
    p0 = pulses;
    bus.buff_we = 1'b1; tick(); bus.buff_we = 1'b0;
    bus.busy = 1'b1; bus.mtr = 1'b0;
    tick();
    repeat (50) tick();
    check("no_save_while_busy", pulses, p0);
    bus.busy = 1'b0;
    tick();
    check("save_after_busy", int'(bus.save_track), 1);
    tick();
    check("one_deferred_pulse", pulses, p0 + 1);
    bus.mtr = 1'b1; tick();

    // Ignored phase patterns and discarded pending save
    step_by(1);
    cnt = int'(bus.half_track);
    step_by(2);
    check("double_jump_ignored", int'(bus.half_track), cnt);
    bus.mtr = 1'b0;
    step_by(1); step_by(1);
    check("motor_off_ignored", int'(bus.half_track), cnt);
    bus.mtr = 1'b1; tick();
    p0 = pulses;
    bus.buff_we = 1'b1; tick(); bus.buff_we = 1'b0;
    bus.busy = 1'b1;
    step_by(1);
    bus.disk_change = 1'b1; tick(); bus.disk_change = 1'b0;
    bus.busy = 1'b0;
    repeat (10) tick();
    check("disk_change_drops_save", pulses, p0);

    // Asynchronous reset in the middle of a pending save and settle
    bus.buff_we = 1'b1; tick(); bus.buff_we = 1'b0;
    bus.busy = 1'b1;
    step_by(1);
    p0 = pulses;
    #3 reset_n = 1'b0;
    #1;
    check("arst_half_track", int'(bus.half_track), 36);
    check("arst_save",       int'(bus.save_track), 0);
    check("arst_settled",    int'(bus.settled), 1);
    check("arst_tr00",       int'(bus.tr00_sense_n), 1);
    tick(); tick();
    reset_n  = 1'b1;
    bus.busy = 1'b0;
    repeat (20) tick();
    check("no_pulse_after_reset", pulses, p0);

    // Randomized traffic alternating busy stepping bursts with quiet spells
    for (int i = 0; i < 3000; i++) begin
      if (((i / 200) % 2) == 0) begin
        if ($urandom_range(0, 3) == 0) bus.stp = 2'(int'(bus.stp) + int'($urandom_range(1, 3)));
      end else begin
        if ($urandom_range(0, 99) == 0) bus.stp = 2'(int'(bus.stp) + int'($urandom_range(1, 3)));
      end
      bus.mtr         = ($urandom_range(0, 19) != 0);
      bus.buff_we     = ($urandom_range(0, 7) == 0);
      bus.disk_change = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 9) == 0) bus.busy = ~bus.busy;
      tick();
    end

    bus.busy = 1'b0;
    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
